// File: rtl/power_sequence_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// power_sequence_scheduler_pkg
// Shared definitions for the power sequence scheduler:
//   - state_t       : sequencing FSM states (idle, power-up steps, power-down
//                     steps, completion)
//   - DEFAULT_*     : default domain count and settle/step delays
//   - next_index()  : round-robin pointer advance helper (wraps at the count)
// -----------------------------------------------------------------------------
package power_sequence_scheduler_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    PU_PWR = 4'd1,
    PU_RST = 4'd2,
    PU_ISO = 4'd3,
    PU_CLK = 4'd4,
    PD_CLK = 4'd5,
    PD_ISO = 4'd6,
    PD_RST = 4'd7,
    PD_PWR = 4'd8,
    DONE   = 4'd9
  } state_t;

  localparam int DEFAULT_DOMAIN_COUNT  = 4;
  localparam int DEFAULT_SETTLE_CYCLES = 16;
  localparam int DEFAULT_STEP_CYCLES   = 2;

  // Index following 'idx' in a ring of 'count' entries.
  function automatic int next_index(input int idx, input int count);
    return (idx >= count - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/power_sequence_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at 'ptr' and
// walks upward (wrapping) through 'req'; the first set bit wins.
// Ports:
//   req    in  N      request vector
//   ptr    in  IDX_W  highest-priority index for this arbitration
//   grant  out N      one-hot grant (all zero when nothing requested)
//   idx    out IDX_W  index of the granted request
//   valid  out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest requester
  // (lowest offset from ptr) is the last writer and therefore wins.
  always_comb begin
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = valid && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/power_sequence_scheduler.sv
// -----------------------------------------------------------------------------
// power_sequence_scheduler
// Serialises per-domain power-up / power-down requests so that only one domain
// switches at a time. Each granted domain is walked through a fixed safe order
// of power switch, reset, isolation and clock enables with settle delays.
// Ports:
//   clk                  in   1      clock
//   rst_n                in   1      synchronous reset, active low
//   req_valid            in   N      per-domain request level, held until req_done
//   req_on               in   N      requested target (1=on), sampled at grant
//   req_done             out  N      one-cycle completion pulse
//   domain_power_on      out  N      power switch enable
//   domain_isolation_on  out  N      output isolation clamp enable
//   domain_reset_n       out  N      domain reset, active low
//   domain_clock_on      out  N      domain clock gate enable
//   domain_status        out  N      1=fully on, 0=fully off
//   domain_transition    out  N      granted domain currently sequencing
//   busy                 out  1      FSM not idle
//   active_idx           out  IDX_W  granted domain index (valid while busy)
// -----------------------------------------------------------------------------
module power_sequence_scheduler
  import power_sequence_scheduler_pkg::*;
#(
  parameter int DOMAIN_COUNT  = DEFAULT_DOMAIN_COUNT,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int STEP_CYCLES   = DEFAULT_STEP_CYCLES,
  localparam int N            = DOMAIN_COUNT,
  localparam int IDX_W        = $clog2(DOMAIN_COUNT),
  localparam int CNT_W        = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N-1:0]     req_on,
  output logic [N-1:0]     req_done,
  output logic [N-1:0]     domain_power_on,
  output logic [N-1:0]     domain_isolation_on,
  output logic [N-1:0]     domain_reset_n,
  output logic [N-1:0]     domain_clock_on,
  output logic [N-1:0]     domain_status,
  output logic [N-1:0]     domain_transition,
  output logic             busy,
  output logic [IDX_W-1:0] active_idx
);

  // Counter reload values: a state held for D cycles loads D-1 on entry and
  // leaves when the counter reads zero. The step delay is expected to be no
  // longer than the settle delay, which sizes the counter.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_reg,  state_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [IDX_W-1:0] ptr_reg,    ptr_next;
  logic [IDX_W-1:0] active_reg, active_next;
  logic [N-1:0]     power_reg,  power_next;
  logic [N-1:0]     iso_reg,    iso_next;
  logic [N-1:0]     rstn_reg,   rstn_next;
  logic [N-1:0]     clken_reg,  clken_next;
  logic [N-1:0]     status_reg, status_next;
  logic [N-1:0]     trans_reg,  trans_next;
  logic [N-1:0]     done_reg,   done_next;

  logic [N-1:0]     grant_vec;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             cnt_zero;

  rr_arbiter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_arbiter (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant_vec),
    .idx   (grant_idx),
    .valid (grant_valid)
  );

  assign cnt_zero = (cnt_reg == '0);

  // Every output change is made on the transition into the state that owns
  // it, so each control edge appears in the first cycle of that state.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    ptr_next    = ptr_reg;
    active_next = active_reg;
    power_next  = power_reg;
    iso_next    = iso_reg;
    rstn_next   = rstn_reg;
    clken_next  = clken_reg;
    status_next = status_reg;
    trans_next  = trans_reg;
    done_next   = '0;

    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          active_next = grant_idx;
          ptr_next    = IDX_W'(next_index(int'(grant_idx), N));
          trans_next  = grant_vec;
          if (req_on[grant_idx] == status_reg[grant_idx]) begin
            // Already in the requested state: acknowledge without touching
            // any control output.
            state_next = DONE;
            done_next  = grant_vec;
          end else if (req_on[grant_idx]) begin
            state_next = PU_PWR;
            power_next = power_reg | grant_vec;
            cnt_next   = SETTLE_LOAD;
          end else begin
            state_next = PD_CLK;
            clken_next = clken_reg & ~grant_vec;
            cnt_next   = STEP_LOAD;
          end
        end
      end

      PU_PWR: begin
        if (cnt_zero) begin
          state_next            = PU_RST;
          rstn_next[active_reg] = 1'b1;
          cnt_next              = STEP_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      PU_RST: begin
        if (cnt_zero) begin
          state_next           = PU_ISO;
          iso_next[active_reg] = 1'b0;
          cnt_next             = STEP_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      PU_ISO: begin
        if (cnt_zero) begin
          state_next             = PU_CLK;
          clken_next[active_reg] = 1'b1;
          cnt_next               = '0;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      PU_CLK: begin
        if (cnt_zero) begin
          state_next              = DONE;
          status_next[active_reg] = 1'b1;
          done_next[active_reg]   = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      PD_CLK: begin
        if (cnt_zero) begin
          state_next           = PD_ISO;
          iso_next[active_reg] = 1'b1;
          cnt_next             = STEP_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      PD_ISO: begin
        if (cnt_zero) begin
          state_next            = PD_RST;
          rstn_next[active_reg] = 1'b0;
          cnt_next              = STEP_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      PD_RST: begin
        if (cnt_zero) begin
          state_next             = PD_PWR;
          power_next[active_reg] = 1'b0;
          cnt_next               = SETTLE_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      PD_PWR: begin
        if (cnt_zero) begin
          state_next              = DONE;
          status_next[active_reg] = 1'b0;
          done_next[active_reg]   = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      DONE: begin
        // Always pass through IDLE so arbitration gets its own cycle.
        state_next = IDLE;
        trans_next = '0;
      end

      default: begin
        state_next = IDLE;
        trans_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      ptr_reg    <= '0;
      active_reg <= '0;
      power_reg  <= '0;
      iso_reg    <= '1;
      rstn_reg   <= '0;
      clken_reg  <= '0;
      status_reg <= '0;
      trans_reg  <= '0;
      done_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ptr_reg    <= ptr_next;
      active_reg <= active_next;
      power_reg  <= power_next;
      iso_reg    <= iso_next;
      rstn_reg   <= rstn_next;
      clken_reg  <= clken_next;
      status_reg <= status_next;
      trans_reg  <= trans_next;
      done_reg   <= done_next;
    end
  end

  assign req_done            = done_reg;
  assign domain_power_on     = power_reg;
  assign domain_isolation_on = iso_reg;
  assign domain_reset_n      = rstn_reg;
  assign domain_clock_on     = clken_reg;
  assign domain_status       = status_reg;
  assign domain_transition   = trans_reg;
  assign busy                = (state_reg != IDLE);
  assign active_idx          = active_reg;

endmodule

// File: tb/tb_power_sequence_scheduler.sv
// -----------------------------------------------------------------------------
// tb_power_sequence_scheduler
// Scoreboard bench: the stimulus pushes the expected completion record of
// every request it issues; a monitor watches the outputs each cycle, records
// when the active domain's controls change, and checks each req_done pulse
// against the next expected record. Structural invariants are checked every
// cycle outside reset.
// -----------------------------------------------------------------------------
module tb_power_sequence_scheduler;

  localparam int N = 4;

  localparam int K_PU   = 0;
  localparam int K_PD   = 1;
  localparam int K_NOOP = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_on;
  logic [N-1:0] req_done;
  logic [N-1:0] domain_power_on;
  logic [N-1:0] domain_isolation_on;
  logic [N-1:0] domain_reset_n;
  logic [N-1:0] domain_clock_on;
  logic [N-1:0] domain_status;
  logic [N-1:0] domain_transition;
  logic         busy;
  logic [1:0]   active_idx;

  power_sequence_scheduler #(
    .DOMAIN_COUNT  (4),
    .SETTLE_CYCLES (16),
    .STEP_CYCLES   (2)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_on              (req_on),
    .req_done            (req_done),
    .domain_power_on     (domain_power_on),
    .domain_isolation_on (domain_isolation_on),
    .domain_reset_n      (domain_reset_n),
    .domain_clock_on     (domain_clock_on),
    .domain_status       (domain_status),
    .domain_transition   (domain_transition),
    .busy                (busy),
    .active_idx          (active_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int       idx;
    int       lat;
    int       pwr_c;
    int       rst_c;
    int       iso_c;
    int       clk_c;
    logic [3:0] pwr;
    logic [3:0] iso;
    logic [3:0] rstn;
    logic [3:0] clken;
    logic [3:0] status;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] model_on = 4'b0000;

  function automatic void chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  // Expected change cycles relative to the grant cycle (0 = no change).
  function automatic void push_exp(input int d, input int kind);
    exp_t e;
    e.idx = d;
    if (kind == K_PU) begin
      e.lat = 22; e.pwr_c = 1; e.rst_c = 17; e.iso_c = 19; e.clk_c = 21;
      model_on[d] = 1'b1;
    end else if (kind == K_PD) begin
      e.lat = 23; e.clk_c = 1; e.iso_c = 3; e.rst_c = 5; e.pwr_c = 7;
      model_on[d] = 1'b0;
    end else begin
      e.lat = 1; e.pwr_c = 0; e.rst_c = 0; e.iso_c = 0; e.clk_c = 0;
    end
    e.pwr    = model_on;
    e.iso    = ~model_on;
    e.rstn   = model_on;
    e.clken  = model_on;
    e.status = model_on;
    exp_q.push_back(e);
  endfunction

  // ---------------------------------------------------------------- monitor
  logic [3:0] prev_pwr, prev_iso, prev_rstn, prev_clk;
  logic       in_seq = 1'b0;
  int         t0 = 0;
  int         act_d = 0;
  int         pc = 0, rc = 0, ic = 0, cc = 0;
  logic       bad;
  exp_t       e_mon;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_seq = 1'b0;
    end else begin
      if (busy && !in_seq) begin
        in_seq = 1'b1;
        t0     = cyc - 1;
        act_d  = int'(active_idx);
        pc = 0; rc = 0; ic = 0; cc = 0;
      end
      if (in_seq) begin
        if (pc == 0 && domain_power_on[act_d]     != prev_pwr[act_d])  pc = cyc - t0;
        if (rc == 0 && domain_reset_n[act_d]      != prev_rstn[act_d]) rc = cyc - t0;
        if (ic == 0 && domain_isolation_on[act_d] != prev_iso[act_d])  ic = cyc - t0;
        if (cc == 0 && domain_clock_on[act_d]     != prev_clk[act_d])  cc = cyc - t0;
      end

      // Invariants and one-domain-at-a-time checks.
      bad = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (domain_clock_on[j] &&
            !(!domain_isolation_on[j] && domain_reset_n[j] && domain_power_on[j])) bad = 1'b1;
        if (!domain_power_on[j] &&
            !(domain_isolation_on[j] && !domain_reset_n[j] && !domain_clock_on[j])) bad = 1'b1;
        if (in_seq && j != act_d &&
            (domain_power_on[j] != prev_pwr[j] || domain_reset_n[j] != prev_rstn[j] ||
             domain_isolation_on[j] != prev_iso[j] || domain_clock_on[j] != prev_clk[j])) bad = 1'b1;
      end
      if (!$onehot0(domain_transition)) bad = 1'b1;
      if (busy != (|domain_transition)) bad = 1'b1;
      if (busy && domain_transition != (4'b0001 << act_d)) bad = 1'b1;
      chk("invariants", int'(bad), 0);

      if (req_done != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", int'(req_done), 0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("done_vec",    int'(req_done), 1 << e_mon.idx);
          chk("active_idx",  int'(active_idx), e_mon.idx);
          chk("latency",     in_seq ? (cyc - t0) : -1, e_mon.lat);
          chk("pwr_cycle",   pc, e_mon.pwr_c);
          chk("rst_cycle",   rc, e_mon.rst_c);
          chk("iso_cycle",   ic, e_mon.iso_c);
          chk("clk_cycle",   cc, e_mon.clk_c);
          chk("power_vec",   int'(domain_power_on),     int'(e_mon.pwr));
          chk("iso_vec",     int'(domain_isolation_on), int'(e_mon.iso));
          chk("reset_vec",   int'(domain_reset_n),      int'(e_mon.rstn));
          chk("clock_vec",   int'(domain_clock_on),     int'(e_mon.clken));
          chk("status_vec",  int'(domain_status),       int'(e_mon.status));
          $display("done domain %0d latency %0d (cycle %0d)", e_mon.idx, cyc - t0, cyc);
        end
        in_seq = 1'b0;
      end
    end
    prev_pwr  = domain_power_on;
    prev_iso  = domain_isolation_on;
    prev_rstn = domain_reset_n;
    prev_clk  = domain_clock_on;
  end

  // --------------------------------------------------------------- stimulus
  // Waits for every domain in 'mask' to report done, dropping each request
  // right after its pulse so the following IDLE cycle does not re-grant it.
  task automatic wait_all(input logic [3:0] mask);
    logic [3:0] pending;
    logic [3:0] hit;
    int         n;
    pending = mask;
    n       = 0;
    while (pending != 4'b0000 && n < 400) begin
      @(negedge clk);
      n++;
      hit = req_done & pending;
      if (hit != 4'b0000) begin
        pending = pending & ~hit;
        #1;
        req_valid = req_valid & ~hit;
      end
    end
    chk("all_done", int'(pending), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_power"}, int'(domain_power_on),     0);
    chk({tag, "_iso"},   int'(domain_isolation_on), 15);
    chk({tag, "_rstn"},  int'(domain_reset_n),      0);
    chk({tag, "_clock"}, int'(domain_clock_on),     0);
    chk({tag, "_stat"},  int'(domain_status),       0);
    chk({tag, "_trans"}, int'(domain_transition),   0);
    chk({tag, "_done"},  int'(req_done),            0);
    chk({tag, "_busy"},  int'(busy),                0);
    chk({tag, "_aidx"},  int'(active_idx),          0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_on    = 4'b0000;

    // 1: reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    $display("reset values checked (cycle %0d)", cyc);
    rst_n = 1'b1;

    // 2: power up domain 0.
    push_exp(0, K_PU);
    req_on    = 4'b0001;
    req_valid = 4'b0001;
    wait_all(4'b0001);

    // 3: power down domain 0.
    push_exp(0, K_PD);
    req_on    = 4'b0000;
    req_valid = 4'b0001;
    wait_all(4'b0001);

    // Bring domain 1 up, then 5: repeat the same request as a no-op.
    push_exp(1, K_PU);
    req_on    = 4'b0010;
    req_valid = 4'b0010;
    wait_all(4'b0010);
    push_exp(1, K_NOOP);
    req_valid = 4'b0010;
    wait_all(4'b0010);

    // 4: all four request on with the pointer at 2 -> order 2,3,0,1.
    push_exp(2, K_PU);
    push_exp(3, K_PU);
    push_exp(0, K_PU);
    push_exp(1, K_NOOP);
    req_on    = 4'b1111;
    req_valid = 4'b1111;
    wait_all(4'b1111);

    // Power domain 3 down so it can be powered up again for the reset test.
    push_exp(3, K_PD);
    req_on    = 4'b0111;
    req_valid = 4'b1000;
    wait_all(4'b1000);

    // 6: reset asserted at cycle 10 of a power-up of domain 3.
    @(posedge clk);
    #1;
    req_on    = 4'b1111;
    req_valid = 4'b1000;
    repeat (10) @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    check_reset_values("midreset");
    model_on = 4'b0000;
    rst_n    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_busy",  int'(busy),            0);
    chk("post_reset_power", int'(domain_power_on), 0);
    $display("mid-sequence reset checked (cycle %0d)", cyc);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
